// File: rtl/wt_mem_req_sched_pkg.sv
// Shared types and constants for the write-through dcache memory request scheduler.
//   - Geometry of the request port (address, data, byte enables, load TIDs).
//   - sched_state_e: scheduler FSM states.
//   - mem_req_t:     payload held in the single outgoing request slot.
package wt_sched_pkg;

  localparam int NumTids      = 4;
  localparam int TidW         = $clog2(NumTids);
  localparam int MaxOutStores = 7;
  localparam int AddrWidth    = 34;
  localparam int DataWidth    = 64;
  localparam int BeWidth      = DataWidth / 8;
  localparam int CntW         = 3;

  localparam logic [CntW-1:0] MaxStCnt = CntW'(MaxOutStores);

  typedef enum logic [2:0] {
    ARB,
    NC_DRAIN,
    NC_ISSUE,
    FENCE,
    WAIT_LOW
  } sched_state_e;

  typedef struct packed {
    logic                 store;
    logic [TidW-1:0]      tid;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
    logic [BeWidth-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/wt_mem_req_sched_tid_alloc.sv
// Load transaction ID pool.
//   clk_i, rst_i      clock, synchronous active-high reset (all TIDs free)
//   alloc_i           mark alloc_tid_o busy at this edge
//   alloc_tid_o       lowest free TID
//   free_i/free_tid_i release free_tid_i at this edge (only if it is busy)
//   free_tid_busy_o   free_tid_i is currently busy (used for error detection)
//   all_free_o        no TID in use
//   none_free_o       every TID in use
module wt_tid_alloc
  import wt_sched_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alloc_i,
  output logic [TidW-1:0] alloc_tid_o,
  input  logic            free_i,
  input  logic [TidW-1:0] free_tid_i,
  output logic            free_tid_busy_o,
  output logic            all_free_o,
  output logic            none_free_o
);

  logic [NumTids-1:0] busy_q, busy_d;

  // Scan from the top so the last assignment wins with the lowest free index.
  always_comb begin
    alloc_tid_o = '0;
    for (int i = NumTids - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tid_o = TidW'(i);
    end
  end

  assign free_tid_busy_o = busy_q[free_tid_i];
  assign all_free_o      = (busy_q == '0);
  assign none_free_o     = &busy_q;

  // A TID freed this cycle is not yet visible as free, so the alloc and free
  // masks are always disjoint.
  always_comb begin
    busy_d = busy_q;
    if (free_i && busy_q[free_tid_i]) busy_d[free_tid_i] = 1'b0;
    if (alloc_i && !none_free_o)      busy_d[alloc_tid_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/wt_mem_req_sched.sv
// Request scheduler between the write-through dcache and its memory request port.
// Arbitrates round-robin between the miss unit (loads) and the write buffer
// (stores), allocates load TIDs, caps in-flight stores, and drains all traffic
// before non-idempotent loads and fences proceed.
//   clk_i, rst_i            clock, synchronous active-high reset
//   miss_*                  load request handshake (addr, non-idempotent flag)
//   st_*                    store request handshake (addr, data, byte enables)
//   fence_i / fence_done_o  level fence request / one-cycle completion pulse
//   mem_req_*               registered memory request slot
//   mem_rtrn_*              load responses and store acks
//   st_pending_o            stores accepted but not yet acked
//   idle_o                  nothing in flight, slot empty, arbitrating
//   err_o                   sticky protocol error (bad response/ack)
module wt_mem_req_sched
  import wt_sched_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 miss_valid_i,
  output logic                 miss_ready_o,
  input  logic [AddrWidth-1:0] miss_addr_i,
  input  logic                 miss_nc_i,
  input  logic                 st_valid_i,
  output logic                 st_ready_o,
  input  logic [AddrWidth-1:0] st_addr_i,
  input  logic [DataWidth-1:0] st_data_i,
  input  logic [BeWidth-1:0]   st_be_i,
  input  logic                 fence_i,
  output logic                 fence_done_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_req_store_o,
  output logic [TidW-1:0]      mem_req_tid_o,
  output logic [AddrWidth-1:0] mem_req_addr_o,
  output logic [DataWidth-1:0] mem_req_data_o,
  output logic [BeWidth-1:0]   mem_req_be_o,
  input  logic                 mem_rtrn_valid_i,
  input  logic                 mem_rtrn_store_i,
  input  logic [TidW-1:0]      mem_rtrn_tid_i,
  output logic [CntW-1:0]      st_pending_o,
  output logic                 idle_o,
  output logic                 err_o
);

  sched_state_e    state_q;
  logic            fence_done_q;
  logic            req_valid_q, req_valid_d;
  mem_req_t        req_q, req_d;
  logic [CntW-1:0] st_count_q, st_count_d;
  logic            prio_load_q, prio_load_d;
  logic            err_q, err_d;

  logic            slot_free, drain_ok;
  logic            st_ack, st_ack_ok, ld_rtrn, ld_rtrn_ok;
  logic            store_room, load_elig, store_elig;
  logic            grant_load, grant_nc, grant_store, grant_any_load;
  logic [TidW-1:0] alloc_tid;
  logic            rtrn_tid_busy, tids_all_free, tids_none_free;

  wt_tid_alloc u_tid_alloc (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alloc_i         (grant_any_load),
    .alloc_tid_o     (alloc_tid),
    .free_i          (ld_rtrn_ok),
    .free_tid_i      (mem_rtrn_tid_i),
    .free_tid_busy_o (rtrn_tid_busy),
    .all_free_o      (tids_all_free),
    .none_free_o     (tids_none_free)
  );

  assign slot_free = !req_valid_q || mem_req_ready_i;
  assign drain_ok  = !req_valid_q && (st_count_q == '0) && tids_all_free;

  assign st_ack     = mem_rtrn_valid_i && mem_rtrn_store_i;
  assign st_ack_ok  = st_ack && (st_count_q != '0);
  assign ld_rtrn    = mem_rtrn_valid_i && !mem_rtrn_store_i;
  assign ld_rtrn_ok = ld_rtrn && rtrn_tid_busy;

  // An ack arriving in the same cycle frees a slot, so a store may be taken
  // at the cap without the count ever exceeding it.
  assign store_room = (st_count_q < MaxStCnt) || st_ack_ok;

  assign load_elig  = (state_q == ARB) && miss_valid_i && !miss_nc_i &&
                      !tids_none_free && slot_free;
  assign store_elig = (state_q == ARB) && st_valid_i && !fence_i &&
                      store_room && slot_free;

  // Round-robin: the pointer names the favoured requester and flips to the
  // other side after each grant.
  assign grant_load     = load_elig && (prio_load_q || !store_elig);
  assign grant_store    = store_elig && !grant_load;
  assign grant_nc       = (state_q == NC_ISSUE) && miss_valid_i && slot_free;
  assign grant_any_load = grant_load || grant_nc;

  assign miss_ready_o = grant_any_load;
  assign st_ready_o   = grant_store;

  // Request slot, store counter, arbitration pointer and error flag.
  always_comb begin
    req_valid_d = req_valid_q;
    req_d       = req_q;
    prio_load_d = prio_load_q;
    st_count_d  = st_count_q;
    err_d       = err_q;

    if (grant_any_load) begin
      req_valid_d = 1'b1;
      req_d       = '{store: 1'b0, tid: alloc_tid, addr: miss_addr_i,
                      data: '0, be: '0};
    end else if (grant_store) begin
      req_valid_d = 1'b1;
      req_d       = '{store: 1'b1, tid: '0, addr: st_addr_i,
                      data: st_data_i, be: st_be_i};
    end else if (mem_req_ready_i) begin
      req_valid_d = 1'b0;
    end

    if (grant_load)  prio_load_d = 1'b0;
    if (grant_store) prio_load_d = 1'b1;

    case ({grant_store, st_ack_ok})
      2'b10:   st_count_d = st_count_q + 1'b1;
      2'b01:   st_count_d = st_count_q - 1'b1;
      default: st_count_d = st_count_q;
    endcase

    if (st_ack && (st_count_q == '0)) err_d = 1'b1;
    if (ld_rtrn && !rtrn_tid_busy)    err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_q <= 1'b0;
      req_q       <= '0;
      prio_load_q <= 1'b1;
      st_count_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      req_q       <= req_d;
      prio_load_q <= prio_load_d;
      st_count_q  <= st_count_d;
      err_q       <= err_d;
    end
  end

  // Ordering FSM: nc loads and fences wait for a fully drained port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB;
      fence_done_q <= 1'b0;
    end else begin
      fence_done_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (fence_i)                        state_q <= FENCE;
          else if (miss_valid_i && miss_nc_i) state_q <= NC_DRAIN;
        end
        NC_DRAIN: if (drain_ok) state_q <= NC_ISSUE;
        NC_ISSUE: state_q <= ARB;
        FENCE: begin
          if (drain_ok) begin
            fence_done_q <= 1'b1;
            state_q      <= WAIT_LOW;
          end
        end
        WAIT_LOW: if (!fence_i) state_q <= ARB;
        default:  state_q <= ARB;
      endcase
    end
  end

  assign mem_req_valid_o = req_valid_q;
  assign mem_req_store_o = req_q.store;
  assign mem_req_tid_o   = req_q.tid;
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_data_o  = req_q.data;
  assign mem_req_be_o    = req_q.be;
  assign fence_done_o    = fence_done_q;
  assign st_pending_o    = st_count_q;
  assign err_o           = err_q;
  assign idle_o          = drain_ok && (state_q == ARB);

endmodule

// File: tb/tb_wt_mem_req_sched.sv
module tb_wt_mem_req_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        miss_valid_i, miss_ready_o, miss_nc_i;
  logic [33:0] miss_addr_i;
  logic        st_valid_i, st_ready_o;
  logic [33:0] st_addr_i;
  logic [63:0] st_data_i;
  logic [7:0]  st_be_i;
  logic        fence_i, fence_done_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_store_o;
  logic [1:0]  mem_req_tid_o;
  logic [33:0] mem_req_addr_o;
  logic [63:0] mem_req_data_o;
  logic [7:0]  mem_req_be_o;
  logic        mem_rtrn_valid_i, mem_rtrn_store_i;
  logic [1:0]  mem_rtrn_tid_i;
  logic [2:0]  st_pending_o;
  logic        idle_o, err_o;

  int n_checks = 0;
  int n_fail   = 0;

  wt_mem_req_sched dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .miss_valid_i     (miss_valid_i),
    .miss_ready_o     (miss_ready_o),
    .miss_addr_i      (miss_addr_i),
    .miss_nc_i        (miss_nc_i),
    .st_valid_i       (st_valid_i),
    .st_ready_o       (st_ready_o),
    .st_addr_i        (st_addr_i),
    .st_data_i        (st_data_i),
    .st_be_i          (st_be_i),
    .fence_i          (fence_i),
    .fence_done_o     (fence_done_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_store_o  (mem_req_store_o),
    .mem_req_tid_o    (mem_req_tid_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_data_o   (mem_req_data_o),
    .mem_req_be_o     (mem_req_be_o),
    .mem_rtrn_valid_i (mem_rtrn_valid_i),
    .mem_rtrn_store_i (mem_rtrn_store_i),
    .mem_rtrn_tid_i   (mem_rtrn_tid_i),
    .st_pending_o     (st_pending_o),
    .idle_o           (idle_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    miss_valid_i = 0; miss_addr_i = '0; miss_nc_i = 0;
    st_valid_i = 0; st_addr_i = '0; st_data_i = '0; st_be_i = '0;
    fence_i = 0; mem_req_ready_i = 0;
    mem_rtrn_valid_i = 0; mem_rtrn_store_i = 0; mem_rtrn_tid_i = '0;
  endtask

  task automatic do_reset;
    rst_i = 1;
    clear_inputs();
    step();
    step();
    rst_i = 0;
  endtask

  // One cycle of response / ack traffic.
  task automatic rtrn(input logic st, input logic [1:0] tid);
    mem_rtrn_valid_i = 1; mem_rtrn_store_i = st; mem_rtrn_tid_i = tid;
    step();
    mem_rtrn_valid_i = 0; mem_rtrn_store_i = 0; mem_rtrn_tid_i = '0;
  endtask

  task automatic test_reset;
    rst_i = 1;
    clear_inputs();
    step();
    step();
    n_checks++; if (mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", mem_req_valid_o); end
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b expected 1", idle_o); end
    n_checks++; if (st_pending_o !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", st_pending_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", err_o); end
    n_checks++; if (fence_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_fence_done: got %0b expected 0", fence_done_o); end
    n_checks++; if (mem_req_addr_o !== 34'h0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", mem_req_addr_o); end
    rst_i = 0;
  endtask

  task automatic test_load_hold;
    do_reset();
    miss_valid_i = 1; miss_addr_i = 34'h0_8000_0000;
    #1;
    n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL hold_accept: got %0b expected 1", miss_ready_o); end
    step();
    miss_valid_i = 0;
    n_checks++; if (mem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_valid_n1: got %0b expected 1", mem_req_valid_o); end
    n_checks++; if (mem_req_store_o !== 1'b0) begin n_fail++; $display("FAIL hold_store: got %0b expected 0", mem_req_store_o); end
    n_checks++; if (mem_req_tid_o !== 2'd0) begin n_fail++; $display("FAIL hold_tid: got %0d expected 0", mem_req_tid_o); end
    n_checks++; if (mem_req_addr_o !== 34'h0_8000_0000) begin n_fail++; $display("FAIL hold_addr: got %0h expected 80000000", mem_req_addr_o); end
    for (int i = 0; i < 3; i++) begin
      miss_valid_i = 1; miss_addr_i = 34'h0_0000_1234;
      #1;
      n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_blocked[%0d]: got %0b expected 0", i, miss_ready_o); end
      step();
      n_checks++; if (mem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %0b expected 1", i, mem_req_valid_o); end
      n_checks++; if (mem_req_addr_o !== 34'h0_8000_0000) begin n_fail++; $display("FAIL hold_addr_stable[%0d]: got %0h expected 80000000", i, mem_req_addr_o); end
      n_checks++; if (mem_req_tid_o !== 2'd0) begin n_fail++; $display("FAIL hold_tid_stable[%0d]: got %0d expected 0", i, mem_req_tid_o); end
    end
    miss_valid_i = 0; mem_req_ready_i = 1;
    step();
    n_checks++; if (mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %0b expected 0", mem_req_valid_o); end
    n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL hold_tid_busy_idle: got %0b expected 0", idle_o); end
    rtrn(1'b0, 2'd0);
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL hold_idle_after_rsp: got %0b expected 1", idle_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL hold_err: got %0b expected 0", err_o); end
  endtask

  task automatic test_round_robin;
    logic [3:0] pat;
    logic [1:0] exp_tid;
    pat = 4'b1010;  // bit i = 1 when grant i is a store
    do_reset();
    mem_req_ready_i = 1;
    miss_valid_i = 1; miss_addr_i = 34'h0_0000_0100;
    st_valid_i = 1; st_addr_i = 34'h0_0000_0200; st_data_i = 64'hDEAD_BEEF_0123_4567; st_be_i = 8'hF0;
    #1;
    n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL rr_first_load_ready: got %0b expected 1", miss_ready_o); end
    n_checks++; if (st_ready_o !== 1'b0) begin n_fail++; $display("FAIL rr_first_store_ready: got %0b expected 0", st_ready_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_tid = (i == 2) ? 2'd1 : 2'd0;
      n_checks++; if (mem_req_store_o !== pat[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got store=%0b expected %0b", i, mem_req_store_o, pat[i]); end
      n_checks++; if (mem_req_tid_o !== exp_tid) begin n_fail++; $display("FAIL rr_tid[%0d]: got %0d expected %0d", i, mem_req_tid_o, exp_tid); end
      if (i == 1) begin
        n_checks++; if (mem_req_data_o !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL rr_st_data: got %0h expected deadbeef01234567", mem_req_data_o); end
        n_checks++; if (mem_req_be_o !== 8'hF0) begin n_fail++; $display("FAIL rr_st_be: got %0h expected f0", mem_req_be_o); end
        n_checks++; if (mem_req_addr_o !== 34'h0_0000_0200) begin n_fail++; $display("FAIL rr_st_addr: got %0h expected 200", mem_req_addr_o); end
      end
    end
    miss_valid_i = 0; st_valid_i = 0;
    step();
    n_checks++; if (st_pending_o !== 3'd2) begin n_fail++; $display("FAIL rr_pending: got %0d expected 2", st_pending_o); end
  endtask

  task automatic test_store_cap;
    do_reset();
    mem_req_ready_i = 1;
    st_valid_i = 1; st_addr_i = 34'h0_0000_0300; st_data_i = 64'h1; st_be_i = 8'hFF;
    repeat (7) step();
    n_checks++; if (st_pending_o !== 3'd7) begin n_fail++; $display("FAIL cap_pending7: got %0d expected 7", st_pending_o); end
    n_checks++; if (st_ready_o !== 1'b0) begin n_fail++; $display("FAIL cap_ready: got %0b expected 0", st_ready_o); end
    step();
    n_checks++; if (mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL cap_no_issue: got %0b expected 0", mem_req_valid_o); end
    st_addr_i = 34'h0_0000_0308;
    mem_rtrn_valid_i = 1; mem_rtrn_store_i = 1;
    #1;
    n_checks++; if (st_ready_o !== 1'b1) begin n_fail++; $display("FAIL cap_ack_bypass_ready: got %0b expected 1", st_ready_o); end
    step();
    mem_rtrn_valid_i = 0; mem_rtrn_store_i = 0; st_valid_i = 0;
    n_checks++; if (st_pending_o !== 3'd7) begin n_fail++; $display("FAIL cap_ack_and_accept: got %0d expected 7", st_pending_o); end
    n_checks++; if (mem_req_addr_o !== 34'h0_0000_0308) begin n_fail++; $display("FAIL cap_new_addr: got %0h expected 308", mem_req_addr_o); end
    for (int i = 0; i < 7; i++) rtrn(1'b1, 2'd0);
    n_checks++; if (st_pending_o !== 3'd0) begin n_fail++; $display("FAIL cap_drained: got %0d expected 0", st_pending_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL cap_err: got %0b expected 0", err_o); end
  endtask

  task automatic test_tid_exhaust;
    do_reset();
    mem_req_ready_i = 1;
    miss_valid_i = 1; miss_addr_i = 34'h0_0000_0400;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (mem_req_tid_o !== 2'(i)) begin n_fail++; $display("FAIL tid_alloc[%0d]: got %0d expected %0d", i, mem_req_tid_o, i); end
    end
    n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL tid_fifth_blocked: got %0b expected 0", miss_ready_o); end
    step();
    n_checks++; if (mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL tid_no_issue: got %0b expected 0", mem_req_valid_o); end
    rtrn(1'b0, 2'd2);
    n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL tid_freed_ready: got %0b expected 1", miss_ready_o); end
    step();
    miss_valid_i = 0;
    n_checks++; if (mem_req_tid_o !== 2'd2) begin n_fail++; $display("FAIL tid_reuse: got %0d expected 2", mem_req_tid_o); end
    n_checks++; if (mem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL tid_reuse_valid: got %0b expected 1", mem_req_valid_o); end
  endtask

  task automatic test_nc_load;
    do_reset();
    mem_req_ready_i = 1;
    st_valid_i = 1; st_addr_i = 34'h0_0000_0500; st_be_i = 8'h0F;
    repeat (3) step();
    st_valid_i = 0;
    step();
    n_checks++; if (st_pending_o !== 3'd3) begin n_fail++; $display("FAIL nc_pending3: got %0d expected 3", st_pending_o); end
    miss_valid_i = 1; miss_nc_i = 1; miss_addr_i = 34'h2_0000_0040;
    #1;
    n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL nc_not_immediate: got %0b expected 0", miss_ready_o); end
    step();
    st_valid_i = 1;
    #1;
    n_checks++; if (st_ready_o !== 1'b0) begin n_fail++; $display("FAIL nc_drain_blocks_store: got %0b expected 0", st_ready_o); end
    st_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      rtrn(1'b1, 2'd0);
      n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL nc_wait[%0d]: got %0b expected 0", i, miss_ready_o); end
      n_checks++; if (mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL nc_slot_empty[%0d]: got %0b expected 0", i, mem_req_valid_o); end
    end
    step();
    n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL nc_issue_ready: got %0b expected 1", miss_ready_o); end
    step();
    miss_valid_i = 0; miss_nc_i = 0;
    n_checks++; if (mem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL nc_issued: got %0b expected 1", mem_req_valid_o); end
    n_checks++; if (mem_req_tid_o !== 2'd0) begin n_fail++; $display("FAIL nc_tid: got %0d expected 0", mem_req_tid_o); end
    n_checks++; if (mem_req_addr_o !== 34'h2_0000_0040) begin n_fail++; $display("FAIL nc_addr: got %0h expected 200000040", mem_req_addr_o); end
    n_checks++; if (st_pending_o !== 3'd0) begin n_fail++; $display("FAIL nc_alone: got %0d expected 0", st_pending_o); end
  endtask

  task automatic test_fence;
    int pulses;
    do_reset();
    mem_req_ready_i = 1;
    st_valid_i = 1; st_addr_i = 34'h0_0000_0600;
    repeat (2) step();
    st_valid_i = 0;
    step();
    fence_i = 1;
    pulses = 0;
    step();
    st_valid_i = 1;
    #1;
    n_checks++; if (st_ready_o !== 1'b0) begin n_fail++; $display("FAIL fence_blocks_store: got %0b expected 0", st_ready_o); end
    st_valid_i = 0;
    rtrn(1'b1, 2'd0);
    pulses += int'(fence_done_o);
    rtrn(1'b1, 2'd0);
    pulses += int'(fence_done_o);
    n_checks++; if (fence_done_o !== 1'b0) begin n_fail++; $display("FAIL fence_not_early: got %0b expected 0", fence_done_o); end
    repeat (5) begin
      step();
      pulses += int'(fence_done_o);
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL fence_pulse_count: got %0d expected 1", pulses); end
    fence_i = 0;
    step();
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL fence_back_idle: got %0b expected 1", idle_o); end
    n_checks++; if (fence_done_o !== 1'b0) begin n_fail++; $display("FAIL fence_no_second: got %0b expected 0", fence_done_o); end
  endtask

  task automatic test_errors;
    do_reset();
    rtrn(1'b1, 2'd0);
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_spurious_ack: got %0b expected 1", err_o); end
    n_checks++; if (st_pending_o !== 3'd0) begin n_fail++; $display("FAIL err_count_unchanged: got %0d expected 0", st_pending_o); end
    step();
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b expected 1", err_o); end
    do_reset();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %0b expected 0", err_o); end
    rtrn(1'b0, 2'd1);
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_free_tid_rsp: got %0b expected 1", err_o); end
    do_reset();
    mem_req_ready_i = 1;
    st_valid_i = 1; st_addr_i = 34'h0_0000_0700;
    step();
    st_valid_i = 0; fence_i = 1;
    step();
    step();
    n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL midfence_busy: got %0b expected 0", idle_o); end
    rst_i = 1;
    step();
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL midfence_reset_idle: got %0b expected 1", idle_o); end
    n_checks++; if (st_pending_o !== 3'd0) begin n_fail++; $display("FAIL midfence_reset_count: got %0d expected 0", st_pending_o); end
    fence_i = 0; rst_i = 0;
    step();
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL midfence_stays_idle: got %0b expected 1", idle_o); end
    n_checks++; if (fence_done_o !== 1'b0) begin n_fail++; $display("FAIL midfence_no_pulse: got %0b expected 0", fence_done_o); end
  endtask

  initial begin
    rst_i = 1;
    clear_inputs();
    test_reset();
    test_load_hold();
    test_round_robin();
    test_store_cap();
    test_tid_exhaust();
    test_nc_load();
    test_fence();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
